// File: rtl/spi_pkg.sv
// Shared types and reference arithmetic for the SPI command/result ALU link.
// Command word is {op, a, b}; result is 4 bits.
package spi_pkg;

  typedef enum bit [1:0] {ADD, SUB, INV, RED} opcode_e;

  localparam int CMD_W        = 8;
  localparam int RSP_W        = 4;
  localparam int XFER_PERIODS = 12;

  function automatic logic [RSP_W-1:0] calc_ref(
    input opcode_e    op,
    input logic [2:0] a,
    input logic [2:0] b
  );
    logic [RSP_W-1:0] r;
    r = '0;
    case (op)
      ADD:     r = {1'b0, a} + {1'b0, b};
      SUB:     r = {1'b0, a} - {1'b0, b};
      INV:     r = {1'b0, ~a};
      RED:     r = {3'b000, |b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period timer for the SPI clock: counts 0..CLK_DIV-1 while enabled,
// pulses tick at terminal count and wraps.
import spi_pkg::*;

module spi_sclk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) cnt <= '0;
    else                    cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI master framing {op,a,b} out LSB first and capturing a 4-bit result.
// Define SPI_CMD_MASTER_REF_CHECK_EN to build the rsp_err reference check.
import spi_pkg::*;

module spi_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  opcode_e          req_op,
  input  logic [2:0]       req_a,
  input  logic [2:0]       req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RSP_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int GAP_N = (CS_GAP < 1) ? 1 : CS_GAP;
  localparam int GW    = $clog2(GAP_N + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_N - 1);
  localparam logic [4:0] H_LAST = 5'(2 * XFER_PERIODS - 1);

  logic [2:0]       state;
  logic [CMD_W-1:0] cmd;
  logic [4:0]       hcnt;
  logic [GW-1:0]    gcnt;
  logic [3:0]       nper;
  logic             en;
  logic             tick;

  assign en = (state == S_SETUP) || (state == S_XFER) ||
              (state == S_HOLD);
  assign req_ready = (state == S_IDLE) && !rst;
  assign busy = (state != S_IDLE) && (state != S_GAP);
  // period that starts at the next rising edge (odd half-periods only)
  assign nper = hcnt[4:1] + 4'd1;

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd       <= '0;
      hcnt      <= '0;
      gcnt      <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cmd   <= {req_op, req_a, req_b};
          cs    <= 1'b0;
          mosi  <= req_b[0];
          state <= S_SETUP;
        end
        S_SETUP: if (tick) begin
          sclk  <= 1'b1;
          mosi  <= cmd[0];
          hcnt  <= '0;
          state <= S_XFER;
        end
        S_XFER: if (tick) begin
          if (hcnt == H_LAST) begin
            hcnt  <= '0;
            state <= S_HOLD;
          end else begin
            hcnt <= hcnt + 5'd1;
            sclk <= hcnt[0];
            if (!hcnt[0] && hcnt[4])
              rsp_data[hcnt[2:1]] <= miso;
            if (hcnt[0])
              mosi <= nper[3] ? 1'b0 : cmd[nper[2:0]];
          end
        end
        S_HOLD: if (tick) begin
          cs        <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          gcnt      <= '0;
          state     <= S_GAP;
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) state <= S_IDLE;
          else                  gcnt  <= gcnt + GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_CMD_MASTER_REF_CHECK_EN
  logic [RSP_W-1:0] exp_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid)
        exp_q <= calc_ref(req_op, req_a, req_b);
      if (state == S_HOLD && tick)
        err_q <= (rsp_data != exp_q);
      else if (state == S_DONE && rsp_ready)
        err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
